adc_scan_sequencer: RTL

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_pkg.sv | 15 +
 rtl/scan_delay_counter.sv | 39 +++
 rtl/adc_scan_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/adc_scan_pkg.sv
// Shared types and constants for the ADC row-scan sequencer.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_CONVERT = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_e;

  localparam int              RES_W        = 8;
  localparam logic [RES_W-1:0] TIMEOUT_FILL = 8'hFF;

endpackage

// File: rtl/scan_delay_counter.sv
// Loadable down-counter that times the row settle window and the conversion timeout.
module scan_delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load wins, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {WIDTH{1'b0}})) begin
      cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {WIDTH{1'b0}});

endmodule

// File: rtl/adc_scan_sequencer.sv
// Row-scan sequencer: settle, convert, hand off each row's ADC result, then pulse eof.
// Define SCAN_TIMEOUT_EN to add the conversion timeout and the sticky timeout_err output.
module adc_scan_sequencer
  import adc_scan_pkg::*;
#(
  parameter int ROWS           = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic                    clk,
  input  logic                    n_reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    adc_update,
  input  logic [RES_W-1:0]        adc_data,
  output logic                    adc_enable,
  output logic [ROWS-1:0]         row_sel,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [RES_W-1:0]        res_data,
  output logic [$clog2(ROWS)-1:0] res_row,
  output logic                    eof,
  output logic                    busy
`ifdef SCAN_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  localparam int ROW_W   = $clog2(ROWS);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);
  localparam logic [ROWS-1:0]  ROW_ONE     = {{(ROWS-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`ifdef SCAN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  logic [1:0]       rst_sync_q, rst_sync_d;
  logic             rst_n_s;
  scan_state_e      state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [RES_W-1:0] cap_data_s;
  logic [ROW_W-1:0] cap_row_s;
  logic             cnt_load_s, cnt_dec_s, cnt_zero_s;
  logic [CNT_W-1:0] cnt_load_val_s;
  logic             adc_enable_q, adc_enable_d, res_valid_q, res_valid_d;
  logic             eof_q, eof_d, busy_q, busy_d;
  logic [ROWS-1:0]  row_sel_q, row_sel_d;
  logic [RES_W-1:0] res_data_q, res_data_d;
  logic [ROW_W-1:0] res_row_q, res_row_d;
`ifdef SCAN_TIMEOUT_EN
  logic             timeout_err_q, timeout_err_d;
`endif

  // Reset asserts asynchronously but releases two clocks after n_reset rises.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset release synchroniser.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_s = rst_sync_q[1];

  scan_delay_counter #(.WIDTH(CNT_W)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n_s),
    .load     (cnt_load_s),
    .dec      (cnt_dec_s),
    .load_val (cnt_load_val_s),
    .zero     (cnt_zero_s)
  );

  // Next-state, row advance, capture and delay-counter control.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    cap_data_s     = res_data_q;
    cap_row_s      = res_row_q;
    cnt_load_s     = 1'b0;
    cnt_dec_s      = 1'b0;
    cnt_load_val_s = {CNT_W{1'b0}};
`ifdef SCAN_TIMEOUT_EN
    timeout_err_d  = timeout_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d        = ST_SETTLE;
          row_d          = {ROW_W{1'b0}};
          cnt_load_s     = 1'b1;
          cnt_load_val_s = SETTLE_LOAD;
`ifdef SCAN_TIMEOUT_EN
          timeout_err_d  = 1'b0;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_zero_s) begin
          state_d = ST_CONVERT;
`ifdef SCAN_TIMEOUT_EN
          cnt_load_s     = 1'b1;
          cnt_load_val_s = TIMEOUT_LOAD;
`endif
        end else begin
          cnt_dec_s = 1'b1;
        end
      end
      ST_CONVERT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (adc_update) begin
          state_d    = ST_OUTPUT;
          cap_data_s = adc_data;
          cap_row_s  = row_q;
`ifdef SCAN_TIMEOUT_EN
        end else if (cnt_zero_s) begin
          state_d       = ST_OUTPUT;
          cap_data_s    = TIMEOUT_FILL;
          cap_row_s     = row_q;
          timeout_err_d = 1'b1;
        end else begin
          cnt_dec_s = 1'b1;
        end
`else
        end else begin
          state_d = ST_CONVERT;
        end
`endif
      end
      ST_OUTPUT: begin
        // Abort still lets a simultaneous handshake consume the result.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (res_ready) begin
          if (row_q < LAST_ROW) begin
            state_d        = ST_SETTLE;
            row_d          = row_q + {{(ROW_W-1){1'b0}}, 1'b1};
            cnt_load_s     = 1'b1;
            cnt_load_val_s = SETTLE_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    busy_d       = (state_d != ST_IDLE);
    adc_enable_d = (state_d == ST_CONVERT);
    res_valid_d  = (state_d == ST_OUTPUT);
    eof_d        = (state_d == ST_DONE);
    res_data_d   = res_valid_d ? cap_data_s : {RES_W{1'b0}};
    res_row_d    = res_valid_d ? cap_row_s : {ROW_W{1'b0}};
    if ((state_d == ST_SETTLE) || (state_d == ST_CONVERT) || (state_d == ST_OUTPUT)) begin
      row_sel_d = ROW_ONE << row_d;
    end else begin
      row_sel_d = {ROWS{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q      <= ST_IDLE;
      row_q        <= {ROW_W{1'b0}};
      adc_enable_q <= 1'b0;
      res_valid_q  <= 1'b0;
      eof_q        <= 1'b0;
      busy_q       <= 1'b0;
      row_sel_q    <= {ROWS{1'b0}};
      res_data_q   <= {RES_W{1'b0}};
      res_row_q    <= {ROW_W{1'b0}};
`ifdef SCAN_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      adc_enable_q <= adc_enable_d;
      res_valid_q  <= res_valid_d;
      eof_q        <= eof_d;
      busy_q       <= busy_d;
      row_sel_q    <= row_sel_d;
      res_data_q   <= res_data_d;
      res_row_q    <= res_row_d;
`ifdef SCAN_TIMEOUT_EN
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign adc_enable = adc_enable_q;
  assign row_sel    = row_sel_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_row    = res_row_q;
  assign eof        = eof_q;
  assign busy       = busy_q;
`ifdef SCAN_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule
